// File: rtl/conv_sequencer.sv
// Control FSM for a single convolution engine. It loads an x frame, then walks every
// output position issuing x/filter addresses and accumulator strobes, and hands out y results.
module conv_sequencer #(
  parameter int LENX  = 16,
  parameter int LENF  = 4,
  parameter int ADDRX = 4,
  parameter int ADDRF = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  output logic             x_wr_en,
  output logic [ADDRX-1:0] x_addr,
  output logic [ADDRF-1:0] f_addr,
  output logic             clr_acc,
  output logic             en_acc,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic             y_last
);

  if (LENX < LENF) begin : g_len_check
    $error("conv_sequencer: LENX must be >= LENF");
  end

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2,
    S_OUTPUT  = 2'd3
  } state_e;

  localparam logic [ADDRX-1:0] LAST_WR  = ADDRX'(LENX - 1);
  localparam logic [ADDRX-1:0] LAST_POS = ADDRX'(LENX - LENF);
  localparam logic [ADDRF-1:0] LAST_TAP = ADDRF'(LENF - 1);

  state_e           state_q;
  logic [ADDRX-1:0] wr_cnt_q;
  logic [ADDRX-1:0] pos_q;
  logic [ADDRF-1:0] tap_q;
  logic             clr_acc_q;
  logic             en_acc_q;
  logic             m_valid_y_q;
  logic             y_last_q;

  // s_ready_x is gated by reset so that nothing looks ready while the block is held.
  assign s_ready_x = (state_q == S_LOAD) && reset;
  assign x_wr_en   = s_valid_x && s_ready_x;

  // tap_q parks on the last tap through DRAIN/OUTPUT, so the read addresses hold for free.
  assign x_addr    = (state_q == S_LOAD) ? wr_cnt_q : pos_q + ADDRX'(tap_q);
  assign f_addr    = tap_q;
  assign clr_acc   = clr_acc_q;
  assign en_acc    = en_acc_q;
  assign m_valid_y = m_valid_y_q;
  assign y_last    = y_last_q;

  // NOTE: every register here is state, so it is written with <= only; the async
  // reset clears all strobes at once, so no output can glitch while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= '0;
      pos_q       <= '0;
      tap_q       <= '0;
      clr_acc_q   <= 1'b0;
      en_acc_q    <= 1'b0;
      m_valid_y_q <= 1'b0;
      y_last_q    <= 1'b0;
    end else begin
      // Read data lags the issued address by one cycle, hence the one-cycle enable delay.
      en_acc_q  <= (state_q == S_COMPUTE);
      clr_acc_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (x_wr_en) begin
            if (wr_cnt_q == LAST_WR) begin
              wr_cnt_q  <= '0;
              pos_q     <= '0;
              tap_q     <= '0;
              clr_acc_q <= 1'b1;
              state_q   <= S_COMPUTE;
            end else begin
              wr_cnt_q <= wr_cnt_q + ADDRX'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (tap_q == LAST_TAP) begin
            state_q <= S_DRAIN;
          end else begin
            tap_q <= tap_q + ADDRF'(1);
          end
        end
        S_DRAIN: begin
          m_valid_y_q <= 1'b1;
          y_last_q    <= (pos_q == LAST_POS);
          state_q     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (m_ready_y) begin
            m_valid_y_q <= 1'b0;
            y_last_q    <= 1'b0;
            if (pos_q == LAST_POS) begin
              state_q <= S_LOAD;
            end else begin
              pos_q     <= pos_q + ADDRX'(1);
              tap_q     <= '0;
              clr_acc_q <= 1'b1;
              state_q   <= S_COMPUTE;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Control FSM that sequences one convolution engine: a LENX-entry x sample memory, a LENF-tap filter ROM and a saturating MAC accumulator.
- Loads a full x frame over a valid/ready input stream, then walks every valid output position, issuing memory/ROM addresses and accumulator enable/clear strobes.
- Presents each finished y result on a valid/ready output handshake.
- Contains no datapath arithmetic; generates addresses and strobes only.

Parameters:
- LENX, 16, samples per x frame.
- LENF, 4, filter taps; LENX >= LENF required (elaboration-time check).
- ADDRX, 4, x address width, equal to clog2(LENX).
- ADDRF, 2, filter address width, equal to clog2(LENF).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- s_valid_x  in  1  input sample valid.
- s_ready_x  out  1  sequencer can accept an x sample.
- x_wr_en  out  1  x memory write strobe.
- x_addr  out  ADDRX  x memory address, shared by write and read.
- f_addr  out  ADDRF  filter ROM address.
- clr_acc  out  1  synchronous accumulator clear.
- en_acc  out  1  accumulate the current product.
- m_valid_y  out  1  y result valid.
- m_ready_y  in  1  downstream accepts y.
- y_last  out  1  marks the last y of a frame; qualified by m_valid_y.

Behaviour:
- Reset (reset=0): all outputs and internal counters are 0 immediately; state = LOAD. After release, s_ready_x=1 combinationally from LOAD.
- Memory and ROM have 1-cycle read latency: data for an address issued in cycle t is valid in cycle t+1. en_acc is a register delayed 1 cycle from tap issue.
- States: LOAD, COMPUTE, DRAIN, OUTPUT.
- LOAD:
  - s_ready_x=1; x_addr=wr_cnt; x_wr_en = s_valid_x & s_ready_x.
  - wr_cnt increments only on accept.
  - On accepting wr_cnt==LENX-1: go to COMPUTE with pos=0, tap=0; wr_cnt returns to 0.
- COMPUTE:
  - s_ready_x=0; x_addr=pos+tap; f_addr=tap; tap increments every cycle.
  - clr_acc=1 only in the tap==0 cycle.
  - After issuing tap==LENF-1: go to DRAIN.
- DRAIN:
  - One cycle; en_acc=1 for the final tap; no address issue. x_addr and f_addr hold their last values.
  - Go to OUTPUT.
- OUTPUT:
  - m_valid_y=1; y_last=1 when pos==LENX-LENF.
  - Addresses hold; en_acc=0; clr_acc=0.
  - On m_valid_y & m_ready_y: if pos==LENX-LENF, go to LOAD; else pos+1 and go to COMPUTE with tap=0.
- en_acc=1 exactly LENF consecutive cycles per output, starting the cycle after clr_acc. clr_acc and en_acc are never both 1.
- m_valid_y, once raised, stays 1 with y_last stable until accepted. No y is dropped or duplicated.
- Per-output latency: first address issue to m_valid_y = LENF+1 cycles. Minimum cycles per output = LENF+2.
- Outputs per frame = LENX-LENF+1.
- Counter widths: pos uses ADDRX bits; pos+tap never exceeds LENX-1, so there is no wrap.
- LENF==1: COMPUTE lasts one cycle with clr_acc and the single issue; DRAIN unchanged.
- LENX==LENF: exactly one output per frame.
- Reset during any state aborts the frame: partial x and pending y are discarded, and no strobe glitches during assertion.
- s_valid_x outside LOAD is ignored; x_wr_en=0.

Test Plan:
- Reset, then s_valid_x held 1 with data 0..15 -> x_wr_en with x_addr 0..15 on 16 consecutive cycles; s_ready_x=0 the cycle after the 16th accept.
- First output, m_ready_y=1 -> x_addr 0,1,2,3 and f_addr 0,1,2,3 on consecutive cycles; clr_acc with x_addr=0; en_acc for cycles 2-5; m_valid_y in cycle 6 for one cycle; second position issues x_addr 1..4.
- m_ready_y=0 for 10 cycles during OUTPUT at pos=2 -> m_valid_y stays 1, x_addr/f_addr hold, en_acc=0; release -> next issue x_addr 3,4,5,6.
- Full frame with m_ready_y=1 -> exactly 13 y handshakes, y_last only on the 13th; next cycle s_ready_x=1, next write at x_addr 0.
- Random 50% s_valid_x gaps -> wr_cnt advances only on accept; 16 writes total; compute starts after the 16th.
- reset=0 mid-COMPUTE at pos=5, tap=2 -> all outputs 0 with no clock edge; after release, LOAD with x_addr=0 and no m_valid_y until a new full frame loads.
